// File: rtl/ps2_key_matrix.sv
// PS/2-to-matrix keypad emulator: decoded PS/2 bytes drive per-slot make/break bits
// through a run-time programmable keymap, presented as a scanned matrix plus switches.
//  state    | meaning
//  CLR      | walking the keymap, writing every entry invalid
//  IDLE     | waiting for a byte, no prefix pending
//  EXT      | E0 seen
//  REL      | F0 seen
//  EXT_REL  | E0 F0 seen
//  SKIP     | discarding the remainder of a pause sequence
//  LOOK     | keymap read in flight, apply make/break
module ps2_key_matrix #(
  parameter int NCOLS   = 5,
  parameter int NROWS   = 4,
  parameter int NSW     = 2,
  parameter int TIMEOUT = 0,
  parameter int NKEYS   = NCOLS * NROWS + NSW,
  parameter int KW      = $clog2(NKEYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       kb_data,
  input  logic             kb_valid,
  input  logic             kb_error,
  input  logic             map_we,
  input  logic [8:0]       map_addr,
  input  logic [KW:0]      map_wdata,
  input  logic [NCOLS-1:0] col,
  output logic [NROWS-1:0] row,
  output logic [NSW-1:0]   sw,
  output logic             busy,
  output logic             overrun
);

  localparam logic [2:0] S_CLR     = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_EXT     = 3'd2;
  localparam logic [2:0] S_REL     = 3'd3;
  localparam logic [2:0] S_EXT_REL = 3'd4;
  localparam logic [2:0] S_SKIP    = 3'd5;
  localparam logic [2:0] S_LOOK    = 3'd6;

  localparam int NMAT = NCOLS * NROWS;
  localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]       state;
  logic [8:0]       clr_addr;
  logic [2:0]       skip_cnt;
  logic             rel_q;
  logic [NKEYS-1:0] keys;
  logic             is_ext;
  logic             is_rel;
  logic             wd_fire;

  logic [KW:0]      mem [0:511];
  logic [KW:0]      rd_data;
  logic [8:0]       rd_addr;
  logic             mem_we;
  logic [8:0]       mem_waddr;
  logic [KW:0]      mem_wdata;
  logic             rd_ok;

  assign is_ext = (state == S_EXT) || (state == S_EXT_REL);
  assign is_rel = (state == S_REL) || (state == S_EXT_REL);

  // Host writes are locked out while the clear walk owns the write port.
  assign mem_we    = (state == S_CLR) || map_we;
  assign mem_waddr = (state == S_CLR) ? clr_addr : map_addr;
  assign mem_wdata = (state == S_CLR) ? '0 : map_wdata;
  assign rd_addr   = {is_ext, kb_data};

  // Read-first: a lookup issued alongside a write to the same entry sees the old value.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[rd_addr];
  end

  assign rd_ok = rd_data[KW] && (32'(rd_data[KW-1:0]) < NKEYS);

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [WDW-1:0] wd_cnt;
      always_ff @(posedge clk) begin
        if (reset)                        wd_cnt <= '0;
        else if (kb_valid)                wd_cnt <= '0;
        else if (wd_cnt != WDW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      end
      // Fires on the edge the count lands on TIMEOUT, and keeps firing while saturated.
      assign wd_fire = !kb_valid && (wd_cnt >= WDW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CLR;
      clr_addr <= '0;
      skip_cnt <= '0;
      rel_q    <= 1'b0;
      keys     <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == S_CLR) begin
        clr_addr <= clr_addr + 9'd1;
        if (clr_addr == 9'd511) state <= S_IDLE;
      end else if (kb_error) begin
        state    <= S_IDLE;
        skip_cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_EXT, S_REL, S_EXT_REL: begin
            if (kb_valid) begin
              if (kb_data == 8'hE0) begin
                state <= is_rel ? S_EXT_REL : S_EXT;
              end else if (kb_data == 8'hF0) begin
                state <= is_ext ? S_EXT_REL : S_REL;
              end else if (kb_data == 8'hE1 && state == S_IDLE) begin
                state    <= S_SKIP;
                skip_cnt <= 3'd7;
              end else begin
                rel_q <= is_rel;
                state <= S_LOOK;
              end
            end
          end
          S_SKIP: begin
            if (kb_valid) begin
              if (skip_cnt <= 3'd1) begin
                skip_cnt <= '0;
                state    <= S_IDLE;
              end else begin
                skip_cnt <= skip_cnt - 3'd1;
              end
            end
          end
          S_LOOK: begin
            overrun <= kb_valid;
            state   <= S_IDLE;
            for (int k = 0; k < NKEYS; k++) begin
              if (rd_ok && 32'(rd_data[KW-1:0]) == k) keys[k] <= ~rel_q;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (wd_fire) keys <= '0;
    end
  end

  assign busy = (state == S_CLR);
  assign sw   = keys[NMAT +: NSW];

  // Slot k sits at column NCOLS-1-k/NROWS, row k%NROWS.
  always_comb begin
    row = '0;
    for (int c = 0; c < NCOLS; c++) begin
      for (int r = 0; r < NROWS; r++) begin
        row[r] = row[r] | (col[c] & keys[(NCOLS - 1 - c) * NROWS + r]);
      end
    end
  end

endmodule
